// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch types, constants and FSM states
package cpu_pkg;

    localparam int PC_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] next_pc;
        logic [31:0]     instr;
    } fetch_entry_t;

    typedef enum logic {RUN, FLUSH} fq_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetched instructions; flush dominates push/pop
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wdata,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t         mem_q [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_d  = flush ? '0 : wr_q + PW'(push);
        rd_d  = flush ? '0 : rd_q + PW'(pop);
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    // pointer and count registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // entry storage; needs no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= wdata;
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, imem request credit, redirect FSM and instruction queue for decode
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                IMEM_AW  = 7,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [IMEM_AW-1:0]     imem_addr,
    input  logic [31:0]            imem_data,
    input  logic                   redirect,
    input  logic [ADDR_W-1:0]      redirect_pc,
    input  logic                   deq,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [ADDR_W-1:0]      out_next_pc,
    output logic [$clog2(DEPTH):0] count
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] next_pc;
        logic [31:0]       instr;
    } entry_t;

    localparam int CW = $clog2(DEPTH) + 1;

    fq_state_t         state_q;
    logic [ADDR_W-1:0] fpc_q, ipc_q;
    logic              inflight_q;
    logic              push, pop;
    entry_t            wdata, head;

    // a slot is reserved for every outstanding response, so the queue can never overflow
    assign imem_req  = reset && !redirect && ({1'b0, count} + (CW+1)'(inflight_q) < (CW+1)'(DEPTH));
    assign imem_addr = fpc_q[IMEM_AW-1:0];

    // responses landing in the FLUSH cycle belong to the old path and are dropped
    assign push  = inflight_q && state_q != FLUSH;
    assign pop   = deq && out_valid;
    assign wdata = '{pc: ipc_q, next_pc: ipc_q + ADDR_W'(1), instr: imem_data};

    fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    assign out_valid   = count != '0;
    assign out_instr   = out_valid ? head.instr : NOP_INSTR;
    assign out_pc      = out_valid ? head.pc : '0;
    assign out_next_pc = out_valid ? head.next_pc : '0;

    // fetch PC, in-flight tracking and RUN/FLUSH state; redirect overrides everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            fpc_q      <= RESET_PC;
            ipc_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                fpc_q <= fpc_q + ADDR_W'(1);
                ipc_q <= fpc_q;
            end
            if (redirect) begin
                fpc_q   <= redirect_pc;
                state_q <= FLUSH;
            end else begin
                state_q <= RUN;
            end
        end
    end

endmodule
